// File: rtl/tt_um_serial_sub.sv
// Bit-serial, LSB-first subtractor tile. Operand bits a/b arrive on ui_in
// framed by in_valid/start; each accepted bit produces a registered
// difference bit and borrow one cycle later. After WIDTH bits the assembled
// word A-B (mod 2^WIDTH) is latched onto uio_out together with the
// unsigned-underflow (neg) and zero flags.
//
// Handshake: a bit is taken on a rising edge where ena=1 and in_valid=1, and
// either the FSM is in RUN or start=1 (IDLE ignores bits without start).
// There is no back-pressure. out_valid pulses for one cycle per taken bit.
// done pulses once, together with the out_valid of the final bit.
module tt_um_serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic       bit_a, bit_b, in_valid, start;
  logic       accept, br_in, d_bit, br_next, last_bit;
  logic [3:0] bit_idx, cnt_q;
  logic [7:0] shift_d, shift_q;
  logic       br_q;
  logic       diff_q, borrow_q, out_valid_q, done_q, neg_q, zero_q;
  logic [7:0] result_q;
  logic       unused_inputs;

  assign bit_a    = ui_in[0];
  assign bit_b    = ui_in[1];
  assign in_valid = ui_in[2];
  assign start    = ui_in[3];

  assign unused_inputs = &{1'b0, ui_in[7:4], uio_in};

  // Per-bit datapath: acceptance, full-subtractor cell and next shift value.
  always_comb begin
    accept   = ena & in_valid & ((state_q == S_RUN) | start);
    br_in    = start ? 1'b0 : br_q;
    d_bit    = bit_a ^ bit_b ^ br_in;
    br_next  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_in);
    bit_idx  = start ? 4'd0 : cnt_q;
    last_bit = (bit_idx == 4'(WIDTH - 1));
    // A start bit drops whatever partial word was being assembled.
    shift_d  = start ? 8'h00 : {1'b0, shift_q[7:1]};
    shift_d[WIDTH-1] = d_bit;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  // FSM next state: any accepted bit enters RUN unless it closes the word.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = last_bit ? S_IDLE : S_RUN;
    end
  end

  // Datapath registers: counter, borrow chain, shift register, result/flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= 4'd0;
      br_q        <= 1'b0;
      shift_q     <= 8'h00;
      diff_q      <= 1'b0;
      borrow_q    <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= 8'h00;
      neg_q       <= 1'b0;
      zero_q      <= 1'b1;
    end else if (!ena) begin
      // Pulses are cleared so a stale pulse cannot reappear when ena returns.
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      out_valid_q <= accept;
      done_q      <= accept & last_bit;
      if (accept) begin
        diff_q   <= d_bit;
        borrow_q <= br_next;
        br_q     <= br_next;
        shift_q  <= shift_d;
        cnt_q    <= last_bit ? 4'd0 : bit_idx + 4'd1;
        if (last_bit) begin
          result_q <= shift_d;
          neg_q    <= br_next;
          zero_q   <= (shift_d == 8'h00);
        end
      end
    end
  end

  // Output assembly; pulses are masked while the tile is disabled.
  always_comb begin
    uo_out  = {2'b00, zero_q, neg_q, done_q & ena, out_valid_q & ena,
               borrow_q, diff_q};
    uio_out = result_q;
    uio_oe  = 8'hFF;
  end

endmodule

// File: tb/tb_tt_um_serial_sub.sv
// Bench for tt_um_serial_sub (WIDTH=8). The driver pushes the expected
// per-bit response when it offers an acceptable bit; a negedge monitor pops
// and compares whenever out_valid is seen. Expectations come from plain
// integer arithmetic on the operands, not from a bit-level model.
module tb_tt_um_serial_sub;

  localparam int W = 8;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  // expectation layout: [12]=diff [11]=borrow [10]=done [9:2]=result [1]=neg [0]=zero
  logic [12:0] exp_q[$];

  int checks = 0;
  int passes = 0;

  tt_um_serial_sub #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      passes++;
    end
  endtask

  // reference model: response to bit i of A-B
  function automatic logic [12:0] model_bit(input int a, input int b, input int i);
    int          mask;
    int          diffw;
    logic [12:0] e;
    mask  = (1 << (i + 1)) - 1;
    diffw = (a - b) & 255;
    e[12]  = ((diffw >> i) & 1) != 0;
    e[11]  = (a & mask) < (b & mask);
    e[10]  = (i == W - 1);
    e[9:2] = diffw[7:0];
    e[1]   = a < b;
    e[0]   = (diffw == 0);
    return e;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    logic [12:0] e;
    if (uo_out[2]) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("diff", uo_out[0], e[12]);
        check("borrow", uo_out[1], e[11]);
        check("done", uo_out[3], e[10]);
        if (e[10]) begin
          check("result", uio_out, e[9:2]);
          check("neg", uo_out[4], e[1]);
          check("zero", uo_out[5], e[0]);
        end
      end
    end else if (uo_out[3]) begin
      check("done_without_out_valid", 32'd1, 32'd0);
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      ui_in = {6'b0, 2'($urandom_range(0, 3))};
      @(posedge clk); #1;
    end
    ui_in = 8'h00;
  endtask

  task automatic drive_bit(input logic a, input logic b, input logic st,
                           input logic [12:0] e);
    ui_in = {4'h0, st, 1'b1, b, a};
    exp_q.push_back(e);
    @(posedge clk); #1;
    ui_in = 8'h00;
  endtask

  task automatic send_word(input int a, input int b, input int max_gap);
    for (int i = 0; i < W; i++) begin
      if (i > 0 && max_gap > 0) idle($urandom_range(1, max_gap));
      drive_bit(a[i], b[i], i == 0, model_bit(a, b, i));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 32'd0);
  endtask

  // stimulus
  initial begin
    int a, b;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_uo_out", uo_out, 8'h20);
    check("reset_uio_out", uio_out, 8'h00);
    check("uio_oe", uio_oe, 8'hFF);
    rst_n = 1'b1;

    // in_valid without start while idle must be ignored
    repeat (3) begin
      ui_in = {4'h0, 1'b0, 1'b1, 2'($urandom_range(0, 3))};
      @(posedge clk); #1;
    end
    ui_in = 8'h00;
    idle(2);

    send_word(5, 3, 0);
    drain();
    check("t1_uio_out", uio_out, 8'h02);

    send_word(3, 5, 0);
    drain();
    check("t2_uio_out", uio_out, 8'hFE);

    send_word(8'hA7, 8'hA7, 3);
    drain();

    // back-to-back words, no bubble
    send_word(0, 1, 0);
    send_word(200, 100, 0);
    drain();
    check("t4_uio_out", uio_out, 8'h64);

    // abort at bit 4 by a new start
    for (int i = 0; i < 4; i++) drive_bit(1'((9 >> i) & 1), 1'((2 >> i) & 1),
                                          i == 0, model_bit(9, 2, i));
    for (int i = 0; i < W; i++) begin
      drive_bit(1'((1 >> i) & 1), 1'((1 >> i) & 1), i == 0, model_bit(1, 1, i));
      if (i == 5) check("abort_result_held", uio_out, 8'h64);
    end
    drain();
    check("t5_uio_out", uio_out, 8'h00);

    // mid-word reset
    for (int i = 0; i < 3; i++) drive_bit(1'((77 >> i) & 1), 1'((33 >> i) & 1),
                                          i == 0, model_bit(77, 33, i));
    drain();
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_uo_out", uo_out, 8'h20);
    check("midreset_uio_out", uio_out, 8'h00);
    rst_n = 1'b1;
    send_word(150, 20, 1);
    drain();

    // ena stall for 3 cycles in the middle of a word
    a = $urandom_range(0, 255);
    b = $urandom_range(0, 255);
    for (int i = 0; i < 4; i++) drive_bit(a[i], b[i], i == 0, model_bit(a, b, i));
    idle(1);
    ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ui_in = {4'h0, 1'($urandom_range(0, 1)), 1'b1, 2'($urandom_range(0, 3))};
      @(posedge clk); #1;
      check("stall_pulses_low", uo_out[3:2], 2'b00);
    end
    ui_in = 8'h00;
    ena = 1'b1;
    for (int i = 4; i < W; i++) drive_bit(a[i], b[i], 1'b0, model_bit(a, b, i));
    drain();

    // random words with random gaps, some back-to-back
    for (int n = 0; n < 20; n++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      if (n % 5 == 0) b = a;
      send_word(a, b, $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
